// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The entry struct carries one buffered mul/div result: destination and data.
package wb_arb_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned REG_ZERO       = 0;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding mul/div results awaiting a free write slot.
// Exposes every slot plus its valid bit so the owner can build a busy mask.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output entry_t           head,
  output entry_t           entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// (always wins) and buffered mul/div results drained into idle slots.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 md_valid,
  input  logic [ADDR_W-1:0]    md_addr,
  input  logic [DATA_W-1:0]    md_data,
  output logic                 md_ready,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 pipe_stall,
  output logic [2**ADDR_W-1:0] busy_mask
);

  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic             full;
  logic             empty;
  entry_t           head;
  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic             wb_take;
  logic             push;
  logic             pop;
  logic [AGE_W-1:0] age;

  // md handshake: a result transfers on any cycle with md_valid && md_ready;
  // md_ready depends only on start-of-cycle occupancy, never on md_valid.
  // Transfers to r0 complete but are dropped instead of enqueued.
  assign md_ready = !rst && !full;
  assign push     = md_valid && md_ready && (md_addr != ADDR_W'(REG_ZERO));

  // A pipeline write to r0 is a no-op, so it leaves the port free for the FIFO.
  assign wb_take = wb_valid && (wb_addr != ADDR_W'(REG_ZERO));
  assign pop     = !rst && !wb_take && !empty;

  assign rf_we    = !rst && (wb_take || !empty);
  assign rf_waddr = wb_take ? wb_addr : head.addr;
  assign rf_wdata = wb_take ? wb_data : head.data;

  assign pipe_stall = !rst && ((age >= AGE_W'(STARVE_LIMIT)) || (full && md_valid));

  always_comb begin
    busy_mask = '0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i]) begin
          busy_mask[entries[i].addr] = 1'b1;
        end
      end
    end
  end

  // Age tracks how long the current head has been denied the port.
  always_ff @(posedge clk) begin
    if (rst || empty || pop) begin
      age <= '0;
    end else if (age < AGE_W'(STARVE_LIMIT)) begin
      age <= age + 1'b1;
    end
  end

  wb_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  ('{addr: md_addr, data: md_data}),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .head        (head),
    .entries     (entries),
    .entry_valid (entry_valid)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled 1ns later, well clear of the next edge.
module tb_wb_port_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_addr;
  logic [DATA_W-1:0]    wb_data;
  logic                 md_valid;
  logic [ADDR_W-1:0]    md_addr;
  logic [DATA_W-1:0]    md_data;
  logic                 md_ready;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic                 pipe_stall;
  logic [2**ADDR_W-1:0] busy_mask;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .md_valid   (md_valid),
    .md_addr    (md_addr),
    .md_data    (md_data),
    .md_ready   (md_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pipe_stall (pipe_stall),
    .busy_mask  (busy_mask)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    md_valid = mv; md_addr = ma; md_data = md;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic expect_write(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    check({tag, "_we"}, 64'(rf_we), 64'd1);
    check({tag, "_addr"}, 64'(rf_waddr), 64'(a));
    check({tag, "_data"}, 64'(rf_wdata), 64'(d));
  endtask

  function automatic logic [63:0] bit_of(input int r);
    logic [63:0] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  initial begin
    // reset with busy-looking inputs: everything must stay low
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    next_cycle(); next_cycle();
    settle();
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_ready", 64'(md_ready), 64'd0);
    check("rst_stall", 64'(pipe_stall), 64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);
    rst = 1'b0;
    idle();
    next_cycle();

    // single md result into an idle pipeline, no bypass
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_00AA);
    settle();
    check("t1_ready", 64'(md_ready), 64'd1);
    check("t1_nobypass", 64'(rf_we), 64'd0);
    check("t1_busy0", 64'(busy_mask), 64'd0);
    next_cycle();
    idle();
    settle();
    expect_write("t1_wr", 5'd9, 32'hAA);
    check("t1_busy1", 64'(busy_mask), bit_of(9));
    next_cycle();
    settle();
    check("t1_done_we", 64'(rf_we), 64'd0);
    check("t1_done_busy", 64'(busy_mask), 64'd0);

    // pipeline busy every cycle, fill FIFO, then drain in order
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd5, 32'h55);
    settle();
    check("t2_ready_a", 64'(md_ready), 64'd1);
    expect_write("t2_wb_a", 5'd3, 32'h33);
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd6, 32'h66);
    settle();
    check("t2_ready_b", 64'(md_ready), 64'd1);
    check("t2_busy_b", 64'(busy_mask), bit_of(5));
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    settle();
    check("t2_full_ready", 64'(md_ready), 64'd0);
    check("t2_full_stall", 64'(pipe_stall), 64'd1);
    check("t2_busy_full", 64'(busy_mask), bit_of(5) | bit_of(6));
    expect_write("t2_wb_c", 5'd3, 32'h33);
    next_cycle();
    idle();
    settle();
    expect_write("t2_pop5", 5'd5, 32'h55);
    check("t2_bubble_stall", 64'(pipe_stall), 64'd0);
    next_cycle();
    drive(1'b1, 5'd3, 32'h34, 1'b0, '0, '0);
    settle();
    expect_write("t2_wb_d", 5'd3, 32'h34);
    check("t2_busy_6", 64'(busy_mask), bit_of(6));
    next_cycle();
    idle();
    settle();
    expect_write("t2_pop6", 5'd6, 32'h66);
    next_cycle();
    settle();
    check("t2_empty_we", 64'(rf_we), 64'd0);
    check("t2_empty_busy", 64'(busy_mask), 64'd0);

    // starvation: head ages while the pipeline keeps the port
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'h10A);
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b0, '0, '0);
    for (int c = 0; c < 4; c++) begin
      settle();
      check($sformatf("t3_nostall_%0d", c), 64'(pipe_stall), 64'd0);
      next_cycle();
    end
    settle();
    check("t3_stall", 64'(pipe_stall), 64'd1);
    expect_write("t3_wb", 5'd3, 32'h33);
    next_cycle();
    settle();
    check("t3_stall_sat", 64'(pipe_stall), 64'd1);
    next_cycle();
    idle();
    settle();
    expect_write("t3_pop", 5'd10, 32'h10A);
    check("t3_stall_pop", 64'(pipe_stall), 64'd1);
    next_cycle();
    settle();
    check("t3_stall_drop", 64'(pipe_stall), 64'd0);
    check("t3_idle_we", 64'(rf_we), 64'd0);

    // r0 handling on both sides
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD);
    settle();
    check("t4_r0_ready", 64'(md_ready), 64'd1);
    next_cycle();
    idle();
    settle();
    check("t4_r0_we", 64'(rf_we), 64'd0);
    check("t4_r0_busy", 64'(busy_mask), 64'd0);
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC0);
    next_cycle();
    drive(1'b1, 5'd0, 32'hBEEF, 1'b0, '0, '0);
    settle();
    expect_write("t4_wb_r0_drain", 5'd12, 32'hC0);
    next_cycle();
    idle();
    settle();
    check("t4_after_we", 64'(rf_we), 64'd0);

    // full FIFO: pop and offer in the same cycle, push lands next cycle
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd1, 32'h11);
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1, 5'd4, 32'h44);
    settle();
    check("t5_full_ready", 64'(md_ready), 64'd0);
    expect_write("t5_pop1", 5'd1, 32'h11);
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    settle();
    check("t5_ready_next", 64'(md_ready), 64'd1);
    check("t5_busy_one", 64'(busy_mask), bit_of(2));
    next_cycle();
    idle();
    settle();
    expect_write("t5_pop2", 5'd2, 32'h22);
    check("t5_busy_two", 64'(busy_mask), bit_of(2) | bit_of(4));
    next_cycle();
    settle();
    expect_write("t5_pop4", 5'd4, 32'h44);
    next_cycle();
    settle();
    check("t5_empty_we", 64'(rf_we), 64'd0);

    // reset mid-operation discards pending entries
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd1, 32'h11);
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 5'd8, 32'h88);
    settle();
    check("t6_rst_we", 64'(rf_we), 64'd0);
    check("t6_rst_ready", 64'(md_ready), 64'd0);
    check("t6_rst_stall", 64'(pipe_stall), 64'd0);
    check("t6_rst_busy", 64'(busy_mask), 64'd0);
    next_cycle();
    rst = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("t6_no_stale_%0d", c), 64'(rf_we), 64'd0);
      check($sformatf("t6_busy_%0d", c), 64'(busy_mask), 64'd0);
      next_cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h1234);
    settle();
    check("t6_ready", 64'(md_ready), 64'd1);
    next_cycle();
    idle();
    settle();
    expect_write("t6_fresh", 5'd9, 32'h1234);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
